// File: rtl/dif_nth.sv
// Backward finite difference of order 0..3 on a signed sample stream, one sample per 3 cycles.
// Optional DIF_SAT_EN: clamp narrowed results to the OUT_W signed range and add the dif_sat flag.
//
// state | meaning
// IDLE  | waiting for en_dif; latch sample and order
// CALC  | compute difference, shift history, raise dif_finish
// DONE  | drop dif_finish, return to IDLE
module dif_nth #(
  parameter int DATA_W = 13,
  parameter int OUT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en_dif,
  input  logic [1:0]               dif_order,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] current_data,
  output logic signed [OUT_W-1:0]  dif_data,
  output logic                     dif_finish,
`ifdef DIF_SAT_EN
  output logic                     dif_sat,
`endif
  output logic                     dif_valid
);

  localparam int FULL_W = DATA_W + 3;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t state, state_nxt;

  logic signed [DATA_W-1:0] x0, x1, x2, x3;
  logic [1:0]               ord;
  logic [1:0]               fill;

  logic signed [FULL_W-1:0] e0, e1, e2, e3;
  logic signed [FULL_W-1:0] diff;
  logic signed [OUT_W-1:0]  res_out;
`ifdef DIF_SAT_EN
  logic                     sat_hit;
`endif

  assign e0 = {{3{x0[DATA_W-1]}}, x0};
  assign e1 = {{3{x1[DATA_W-1]}}, x1};
  assign e2 = {{3{x2[DATA_W-1]}}, x2};
  assign e3 = {{3{x3[DATA_W-1]}}, x3};

  // FULL_W holds the worst case 8 * 2^(DATA_W-1), so intermediate wrap cancels out
  always_comb begin
    diff = e0;
    case (ord)
      2'd0: diff = e0;
      2'd1: diff = e0 - e1;
      2'd2: diff = e0 - (e1 <<< 1) + e2;
      default: diff = e0 - ((e1 <<< 1) + e1) + ((e2 <<< 1) + e2) - e3;
    endcase
  end

  generate
    if (OUT_W == FULL_W) begin : g_same
      assign res_out = diff;
`ifdef DIF_SAT_EN
      assign sat_hit = 1'b0;
`endif
    end else if (OUT_W > FULL_W) begin : g_ext
      assign res_out = {{(OUT_W-FULL_W){diff[FULL_W-1]}}, diff};
`ifdef DIF_SAT_EN
      assign sat_hit = 1'b0;
`endif
    end else begin : g_narrow
`ifdef DIF_SAT_EN
      logic top_ones, top_zeros, ovf;
      assign top_ones  = &diff[FULL_W-1:OUT_W-1];
      assign top_zeros = ~|diff[FULL_W-1:OUT_W-1];
      assign ovf       = ~(top_ones | top_zeros);
      assign res_out   = !ovf ? diff[OUT_W-1:0] :
                         diff[FULL_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} :
                                          {1'b0, {(OUT_W-1){1'b1}}};
      assign sat_hit   = ovf;
`else
      assign res_out = OUT_W'(diff);
`endif
    end
  endgenerate

  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (en_dif) state_nxt = CALC;
        CALC:    state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      x0         <= '0;
      x1         <= '0;
      x2         <= '0;
      x3         <= '0;
      ord        <= 2'd3;
      fill       <= 2'd0;
      dif_data   <= '0;
      dif_finish <= 1'b0;
      dif_valid  <= 1'b0;
`ifdef DIF_SAT_EN
      dif_sat    <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (clr) begin
        x1         <= '0;
        x2         <= '0;
        x3         <= '0;
        fill       <= 2'd0;
        dif_finish <= 1'b0;
        dif_valid  <= 1'b0;
`ifdef DIF_SAT_EN
        dif_sat    <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            dif_finish <= 1'b0;
            if (en_dif) begin
              x0  <= current_data;
              ord <= dif_order;
              // an order change restarts warm-up but keeps the history
              if (dif_order != ord) fill <= 2'd0;
            end
          end
          CALC: begin
            dif_data   <= res_out;
            dif_valid  <= (fill >= ord);
            fill       <= (fill == 2'd3) ? 2'd3 : fill + 2'd1;
            x3         <= x2;
            x2         <= x1;
            x1         <= x0;
            dif_finish <= 1'b1;
`ifdef DIF_SAT_EN
            dif_sat    <= sat_hit;
`endif
          end
          default: begin
            dif_finish <= 1'b0;
`ifdef DIF_SAT_EN
            dif_sat    <= 1'b0;
`endif
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dif_nth.sv
// Bench for dif_nth: directed tables, handshake/clr/reset sequences and random stimulus
// against a binomial-sum model; a second instance with OUT_W=13 covers narrowing.
module tb_dif_nth;

  localparam int DW = 13;
  localparam int NW = 13;

  logic clk = 1'b0;
  logic rst;
  logic en_dif;
  logic [1:0] dif_order;
  logic clr;
  logic signed [DW-1:0] current_data;
  logic signed [15:0] d_wide;
  logic signed [NW-1:0] d_nar;
  logic fin_wide, fin_nar, val_wide, val_nar;
`ifdef DIF_SAT_EN
  logic sat_wide, sat_nar;
`endif

  always #5 clk = ~clk;

  dif_nth #(.DATA_W(DW), .OUT_W(16)) dut (
    .clk(clk), .rst(rst), .en_dif(en_dif), .dif_order(dif_order), .clr(clr),
    .current_data(current_data), .dif_data(d_wide), .dif_finish(fin_wide),
`ifdef DIF_SAT_EN
    .dif_sat(sat_wide),
`endif
    .dif_valid(val_wide));

  dif_nth #(.DATA_W(DW), .OUT_W(NW)) dut_n (
    .clk(clk), .rst(rst), .en_dif(en_dif), .dif_order(dif_order), .clr(clr),
    .current_data(current_data), .dif_data(d_nar), .dif_finish(fin_nar),
`ifdef DIF_SAT_EN
    .dif_sat(sat_nar),
`endif
    .dif_valid(val_nar));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // reference model: history newest-first, warm-up counter, last accepted order
  int m_hist[3];
  int m_fill;
  int m_ord;
  int m_res;
  bit m_val;

  function automatic int wrap(input int r, input int w);
    int m, h;
    m = 1 << w;
    h = 1 << (w - 1);
    return ((r + h) % m + m) % m - h;
  endfunction

  function automatic int clamp(input int r, input int w);
    int h;
    h = 1 << (w - 1);
    if (r > h - 1) return h - 1;
    if (r < -h) return -h;
    return r;
  endfunction

  task automatic model_clr();
    for (int i = 0; i < 3; i++) m_hist[i] = 0;
    m_fill = 0;
  endtask

  task automatic model_reset();
    model_clr();
    m_ord = 3;
  endtask

  task automatic model_step(input int o, input int d);
    int h[4];
    int cc, sgn;
    h[0] = d;
    for (int i = 0; i < 3; i++) h[i+1] = m_hist[i];
    m_res = 0;
    cc = 1;
    sgn = 1;
    for (int k = 0; k <= o; k++) begin
      m_res += sgn * cc * h[k];
      cc = cc * (o - k) / (k + 1);
      sgn = -sgn;
    end
    if (o != m_ord) m_fill = 0;
    m_val = (m_fill >= o);
    if (m_fill < 3) m_fill++;
    m_ord = o;
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = d;
  endtask

  int exp_nar;
  bit exp_sat;

  // one full 3-cycle transaction; compares both instances against the model
  task automatic do_sample(input int o, input int d, output int got_d, output int got_v);
    en_dif = 1'b1;
    dif_order = 2'(o);
    current_data = DW'(d);
    @(posedge clk); #1;
    en_dif = 1'b0;
    chk("finish_early", int'(fin_wide), 0);
    @(posedge clk); #1;
    model_step(o, d);
`ifdef DIF_SAT_EN
    exp_nar = clamp(m_res, NW);
    exp_sat = (exp_nar != m_res);
`else
    exp_nar = wrap(m_res, NW);
    exp_sat = 1'b0;
`endif
    chk("finish", int'(fin_wide), 1);
    chk("finish_n", int'(fin_nar), 1);
    chk("data_model", int'(d_wide), wrap(m_res, 16));
    chk("valid_model", int'(val_wide), int'(m_val));
    chk("data_n_model", int'(d_nar), exp_nar);
    chk("valid_n_model", int'(val_nar), int'(m_val));
`ifdef DIF_SAT_EN
    chk("sat_n", int'(sat_nar), int'(exp_sat));
    chk("sat_wide", int'(sat_wide), 0);
`endif
    got_d = int'(d_wide);
    got_v = int'(val_wide);
    @(posedge clk); #1;
    chk("finish_len", int'(fin_wide), 0);
    chk("hold_data", int'(d_wide), got_d);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    model_clr();
  endtask

  typedef struct {
    bit pre_clr;
    int ord;
    int data;
    int exp_d;
    int exp_v;
  } vec_t;

  vec_t tab[$];
  int gd, gv, d, o;
  bit [8:0] pat;

  initial begin
    tab.push_back('{0, 3, 0, 0, 0});
    tab.push_back('{0, 3, 1, 1, 0});
    tab.push_back('{0, 3, 8, 5, 0});
    tab.push_back('{0, 3, 27, 6, 1});
    tab.push_back('{0, 3, 64, 6, 1});
    tab.push_back('{1, 2, 1, 1, 0});
    tab.push_back('{0, 2, 4, 2, 0});
    tab.push_back('{0, 2, 9, 2, 1});
    tab.push_back('{0, 2, 16, 2, 1});
    tab.push_back('{0, 1, 25, 9, 0});
    tab.push_back('{0, 1, 36, 11, 1});
    tab.push_back('{0, 0, -300, -300, 1});

    rst = 1'b1;
    en_dif = 1'b0;
    dif_order = 2'd0;
    clr = 1'b0;
    current_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", int'(d_wide), 0);
    chk("rst_finish", int'(fin_wide), 0);
    chk("rst_valid", int'(val_wide), 0);
    chk("rst_data_n", int'(d_nar), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (tab[i]) begin
      if (tab[i].pre_clr) do_clr();
      do_sample(tab[i].ord, tab[i].data, gd, gv);
      chk($sformatf("tab%0d_data", i), gd, tab[i].exp_d);
      chk($sformatf("tab%0d_valid", i), gv, tab[i].exp_v);
    end

    // en_dif held high: one acceptance per 3 cycles
    en_dif = 1'b1;
    dif_order = 2'd1;
    current_data = 13'sd100;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      pat[i] = fin_wide;
    end
    en_dif = 1'b0;
    for (int i = 0; i < 3; i++) model_step(1, 100);
    chk("hold_pattern", int'(pat), 9'b010010010);
    chk("hold_data", int'(d_wide), m_res);
    chk("hold_valid", int'(val_wide), int'(m_val));

    // clr during CALC after three samples
    do_clr();
    for (int i = 0; i < 3; i++) do_sample(3, 10 * (i + 1), gd, gv);
    en_dif = 1'b1;
    dif_order = 2'd3;
    current_data = 13'sd77;
    @(posedge clk); #1;
    en_dif = 1'b0;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    model_clr();
    chk("clr_no_finish0", int'(fin_wide), 0);
    chk("clr_valid", int'(val_wide), 0);
    @(posedge clk); #1;
    chk("clr_no_finish1", int'(fin_wide), 0);
    do_sample(3, 5, gd, gv);
    chk("clr_first_data", gd, 5);
    chk("clr_first_valid", gv, 0);

    // async reset while in DONE
    en_dif = 1'b1;
    dif_order = 2'd2;
    current_data = 13'sd1000;
    @(posedge clk); #1;
    en_dif = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_finish", int'(fin_wide), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_data", int'(d_wide), 0);
    chk("arst_finish", int'(fin_wide), 0);
    chk("arst_valid", int'(val_wide), 0);
    #1 rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    do_sample(1, -7, gd, gv);
    chk("post_rst_data", gd, -7);
    chk("post_rst_valid", gv, 0);

    // narrowing corner: alternating full-scale samples, order 3
    do_clr();
    do_sample(3, 4095, gd, gv);
    do_sample(3, -4096, gd, gv);
    do_sample(3, 4095, gd, gv);
    do_sample(3, -4096, gd, gv);
    chk("sat_wide_raw", gd, -32764);
`ifdef DIF_SAT_EN
    chk("sat_clamp", int'(d_nar), -4096);
    chk("sat_flag", int'(sat_nar), 1);
`else
    chk("wrap_low_bits", int'(d_nar), 4);
`endif

    // random stream with occasional flushes and order changes
    o = 3;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) do_clr();
      if ($urandom_range(0, 7) == 0) o = $urandom_range(0, 3);
      if ($urandom_range(0, 5) == 0)
        d = ($urandom_range(0, 1) == 1) ? 4095 : -4096;
      else
        d = int'($urandom_range(0, 8191)) - 4096;
      do_sample(o, d, gd, gv);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
